inst_loader: RTL and testbench

Boot-time instruction loader for the minimal SOPC. Accepts a stream of 32-bit instruction words over a valid/ready interface and writes them sequentially into the instruction ROM's memory array. It holds the CPU in reset until the full program is written, then releases it. This is the write side of the instruction ROM, which the core only reads, so benches and boards can load programs without `$readmemh`.

---
 rtl/inst_loader_if.sv | 31 +++
 rtl/inst_loader.sv | 170 +++++++++++++++++
 tb/tb_inst_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_if.sv
// inst_loader bus bundle: start/len request, valid/ready word stream,
// memory write port and CPU reset/status lines.
interface inst_loader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [ADDR_WIDTH:0]   len;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  cpu_rst;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, len, s_valid, s_data,
        input  s_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_rst, busy, done, err
    );

    modport slave (
        input  start, len, s_valid, s_data,
        output s_ready, mem_we, mem_addr, mem_wdata,
        output cpu_rst, busy, done, err
    );
endinterface

// File: rtl/inst_loader.sv
// Boot-time instruction loader: streams words into instruction memory,
// holds the CPU in reset until loaded. Option: INST_LOADER_CHECKSUM_EN.
module inst_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    inst_loader_if.slave bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CW-1:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
`ifdef INST_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_RUN
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         r_len;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_cpu_rst;
    logic                  r_done;
    logic                  r_err;

    logic w_req_ok;
    logic w_last;
    logic w_ready;
    logic w_busy;
    logic w_beat;
    logic w_take;
    logic w_reject;
    logic w_done;
    logic w_cerr;

`ifdef INST_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_sum;
`endif

    assign w_req_ok = (bus.len != '0) && (bus.len <= MAX_LEN);
    assign w_last   = (r_cnt == (r_len - ONE));

    // Next-state and per-cycle strobes for the load sequencer.
    always_comb begin
        w_next   = r_state;
        w_ready  = 1'b0;
        w_busy   = 1'b0;
        w_beat   = 1'b0;
        w_take   = 1'b0;
        w_reject = 1'b0;
        w_done   = 1'b0;
        w_cerr   = 1'b0;
        unique case (r_state)
            S_IDLE, S_RUN: begin
                if (bus.start) begin
                    if (w_req_ok) begin
                        w_take = 1'b1;
                        w_next = S_LOAD;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (bus.s_valid) begin
                    w_beat = 1'b1;
                    if (w_last) begin
`ifdef INST_LOADER_CHECKSUM_EN
                        w_next = S_CHECK;
`else
                        w_next = S_RUN;
                        w_done = 1'b1;
`endif
                    end
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            S_CHECK: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (bus.s_valid) begin
                    if (bus.s_data == r_sum) begin
                        w_next = S_RUN;
                        w_done = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                        w_cerr = 1'b1;
                    end
                end
            end
`endif
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register and status pulses; cpu_rst drops only after a full
    // cycle in RUN so the final write lands before the core fetches.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cpu_rst <= !((r_state == S_RUN) && (w_next == S_RUN));
            r_done    <= w_done;
            r_err     <= w_reject | w_cerr;
        end
    end

    // Word counter, latched length and the registered memory write port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_len   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_beat;
            if (w_take) begin
                r_len <= bus.len;
                r_cnt <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + ONE;
            end
            if (w_beat) begin
                r_addr  <= r_cnt[ADDR_WIDTH-1:0];
                r_wdata <= bus.s_data;
            end
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    // Running mod-2^DATA_WIDTH sum of payload words.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sum <= '0;
        end else if (w_take) begin
            r_sum <= '0;
        end else if (w_beat) begin
            r_sum <= r_sum + bus.s_data;
        end
    end
`endif

    assign bus.s_ready   = w_ready;
    assign bus.busy      = w_busy;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.cpu_rst   = r_cpu_rst;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: table of load requests, write scoreboard,
// hand-written mid-load reset and checksum sequences.
module tb_inst_loader;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NV = 8;

    typedef struct {
        logic [AW:0]         len;
        int                  gap;
        bit                  bad_len;
        logic [3:0][DW-1:0]  w;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   n_done;
    bit   exp_run;
    wr_t  sb[$];
    logic [DW-1:0] wbuf[1 << AW];
    vec_t vec[NV];

    inst_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    inst_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Write monitor: every mem_we must match the oldest expected write.
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (bus.mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {bus.mem_addr, bus.mem_wdata}, 64'h0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
                check("wr_data", 64'(bus.mem_wdata), 64'(e.data));
            end
        end
        if (bus.done === 1'b1) n_done++;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_rst"}, 64'(bus.cpu_rst), 64'd1);
        check({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
        check({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
        check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_err"}, 64'(bus.err), 64'd0);
    endtask

    task automatic send_start(input logic [AW:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        check("beat_ready", 64'(bus.s_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Streams n payload words (plus checksum beat when enabled).
    task automatic feed(input int n, input int gap, input bit bad_ck);
        logic [DW-1:0] sum;
        sum = '0;
        for (int i = 0; i < n; i++) begin
            if (gap != 0 && i > 0) begin
                bus.s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            sb.push_back('{addr: AW'(i), data: wbuf[i]});
            sum = sum + wbuf[i];
            send_beat(wbuf[i]);
        end
`ifdef INST_LOADER_CHECKSUM_EN
        if (gap != 0) begin
            bus.s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        send_beat(bad_ck ? sum + 1 : sum);
`else
        if (bad_ck) check("bad_ck_unsupported", 64'd1, 64'd0);
`endif
        bus.s_valid = 1'b0;
    endtask

    // Called one cycle after the final accepted beat.
    task automatic finish_checks(input int n, input int nd);
        check("fin_done", 64'(bus.done), 64'd1);
        check("fin_s_ready", 64'(bus.s_ready), 64'd0);
        check("fin_busy", 64'(bus.busy), 64'd0);
        check("fin_cpu_rst_hold", 64'(bus.cpu_rst), 64'd1);
`ifndef INST_LOADER_CHECKSUM_EN
        check("fin_last_we", 64'(bus.mem_we), 64'd1);
        check("fin_last_addr", 64'(bus.mem_addr), 64'(n - 1));
`endif
        @(posedge clk);
        #1;
        check("fin_cpu_rst_fall", 64'(bus.cpu_rst), 64'd0);
        check("fin_done_clr", 64'(bus.done), 64'd0);
        check("fin_done_count", 64'(n_done), 64'(nd + 1));
        check("fin_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int nd;
        vec_t v;
        checks   = 0;
        failures = 0;
        n_done   = 0;
        exp_run  = 1'b0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.len     = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        vec[0] = '{len: 11'd0,    gap: 0, bad_len: 1'b1, w: '0};
        vec[1] = '{len: 11'd1025, gap: 0, bad_len: 1'b1, w: '0};
        vec[2] = '{len: 11'd4,    gap: 0, bad_len: 1'b0,
                   w: {32'h00021202, 32'h00021200, 32'h34420404, 32'h3C020404}};
        vec[3] = '{len: 11'd4,    gap: 1, bad_len: 1'b0,
                   w: {32'h00021202, 32'h00021200, 32'h34420404, 32'h3C020404}};
        vec[4] = '{len: 11'd2,    gap: 0, bad_len: 1'b0,
                   w: {32'h0, 32'h0, 32'h00000000, 32'hDEADBEEF}};
        vec[5] = '{len: 11'd2047, gap: 0, bad_len: 1'b1, w: '0};
        vec[6] = '{len: 11'd1,    gap: 0, bad_len: 1'b0,
                   w: {32'h0, 32'h0, 32'h0, 32'h12345678}};
        vec[7] = '{len: 11'd1024, gap: 0, bad_len: 1'b0, w: '0};

        repeat (10) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < NV; k++) begin
            v  = vec[k];
            nd = n_done;
            for (int i = 0; i < int'(v.len) && i < (1 << AW); i++) begin
                wbuf[i] = (v.len <= 4) ? v.w[i] : $urandom;
            end
            send_start(v.len);
            if (v.bad_len) begin
                check("rej_err", 64'(bus.err), 64'd1);
                check("rej_s_ready", 64'(bus.s_ready), 64'd0);
                check("rej_busy", 64'(bus.busy), 64'd0);
                check("rej_cpu_rst", 64'(bus.cpu_rst), 64'(!exp_run));
                @(posedge clk);
                #1;
                check("rej_err_clr", 64'(bus.err), 64'd0);
                check("rej_cpu_rst2", 64'(bus.cpu_rst), 64'(!exp_run));
                check("rej_sb_empty", 64'(sb.size()), 64'd0);
            end else begin
                check("ld_s_ready", 64'(bus.s_ready), 64'd1);
                check("ld_busy", 64'(bus.busy), 64'd1);
                check("ld_cpu_rst", 64'(bus.cpu_rst), 64'd1);
                feed(int'(v.len), v.gap, 1'b0);
                finish_checks(int'(v.len), nd);
                exp_run = 1'b1;
            end
        end

        // Reset after two of four beats; a start during LOAD is ignored.
        nd = n_done;
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA5A50000 + i;
        send_start(11'd4);
        sb.push_back('{addr: AW'(0), data: wbuf[0]});
        send_beat(wbuf[0]);
        sb.push_back('{addr: AW'(1), data: wbuf[1]});
        bus.start = 1'b1;
        bus.len   = '0;
        send_beat(wbuf[1]);
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        check("mid_start_ignored", 64'(bus.err), 64'd0);
        check("mid_we", 64'(bus.mem_we), 64'd1);
        check("mid_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("mid_rst");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_no_done", 64'(n_done), 64'(nd));
        check("mid_sb_empty", 64'(sb.size()), 64'd0);
        check("mid_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        exp_run = 1'b0;

`ifdef INST_LOADER_CHECKSUM_EN
        wbuf[0] = 32'd1;
        wbuf[1] = 32'd2;
        wbuf[2] = 32'd3;
        nd = n_done;
        send_start(11'd3);
        feed(3, 0, 1'b0);
        finish_checks(3, nd);
        nd = n_done;
        send_start(11'd3);
        feed(3, 0, 1'b1);
        check("ck_err", 64'(bus.err), 64'd1);
        check("ck_no_done", 64'(bus.done), 64'd0);
        check("ck_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        check("ck_s_ready", 64'(bus.s_ready), 64'd0);
        check("ck_ck_we", 64'(bus.mem_we), 64'd0);
        @(posedge clk);
        #1;
        check("ck_err_clr", 64'(bus.err), 64'd0);
        check("ck_cpu_rst2", 64'(bus.cpu_rst), 64'd1);
        check("ck_busy", 64'(bus.busy), 64'd0);
        check("ck_done_cnt", 64'(n_done), 64'(nd));
        check("ck_sb_empty", 64'(sb.size()), 64'd0);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
